gate_truth_checker: RTL

Self-checking stimulus/response stage wrapped around the two-input logic gate block. Drives the gate block's a/b inputs through the full truth table 00, 01, 10, 11 and holds each vector for a fixed number of cycles. Samples the five gate outputs after a settle window and compares them against a golden model. Reports per-gate sticky failures, a mismatching-vector count and a final pass/done status, so gate realisations can be checked in hardware without a simulator.

---
 rtl/gate_chk_pkg.sv | 20 ++
 rtl/gate_ref_model.sv | 19 +
 rtl/gate_truth_checker.sv | 116 +++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate truth-table checker.
// Gate output bit order is {NAND, XOR, NOR, OR, AND} = [4:0].
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOR  = 2;
    localparam int GATE_XOR  = 3;
    localparam int GATE_NAND = 4;

    localparam int N_GATES   = 5;
    localparam int N_VECTORS = 4;

endpackage

// File: rtl/gate_ref_model.sv
// Purely combinational golden model of the five two-input gates.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic               a,
    input  logic               b,
    output logic [N_GATES-1:0] expected
);

    always_comb begin
        expected            = '0;
        expected[GATE_AND]  = a & b;
        expected[GATE_OR]   = a | b;
        expected[GATE_NOR]  = ~(a | b);
        expected[GATE_XOR]  = a ^ b;
        expected[GATE_NAND] = ~(a & b);
    end

endmodule

// File: rtl/gate_truth_checker.sv
// Walks a/b through the full truth table, samples the gate block once per vector
// after a settle window and accumulates per-gate sticky failures and a vector error count.
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter int HOLD_CYCLES   = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               a,
    output logic               b,
    input  logic [N_GATES-1:0] gate_i,
    output logic [1:0]         vec_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2:0]         err_count,
    output logic [N_GATES-1:0] err_mask
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       ERR_MAX    = 3'(N_VECTORS);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [N_GATES-1:0] expected;
    logic [N_GATES-1:0] mismatch;
    logic               sample_hit;
    logic [2:0]         err_count_next;
    logic [N_GATES-1:0] err_mask_next;
    logic [1:0]         vec_idx_next;

    gate_ref_model u_ref (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_GATES; gi++) begin : g_cmp
            assign mismatch[gi] = gate_i[gi] ^ expected[gi];
        end
    endgenerate

    // gate_i only matters on the single sample cycle of each vector.
    always_comb begin
        sample_hit     = (state_reg == APPLY) && (cnt_reg == CNT_SAMPLE);
        err_count_next = err_count;
        err_mask_next  = err_mask;
        if (sample_hit) begin
            err_mask_next = err_mask | mismatch;
            if ((|mismatch) && (err_count != ERR_MAX))
                err_count_next = err_count + 3'd1;
        end
        vec_idx_next = vec_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            vec_idx   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            err_mask  <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= APPLY;
                        cnt_reg   <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        vec_idx   <= 2'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        err_mask  <= '0;
                    end
                end
                APPLY: begin
                    err_count <= err_count_next;
                    err_mask  <= err_mask_next;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (vec_idx == 2'd3) begin
                            // Final sample may coincide with the last hold cycle.
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_count_next == 3'd0);
                        end else begin
                            vec_idx <= vec_idx_next;
                            a       <= vec_idx_next[1];
                            b       <= vec_idx_next[0];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
